// File: rtl/dram_block_master.sv
// Block-level initiator for the dual-port DES data memory: 64-bit slot reads/writes become four
// two-byte beats. Defining DRAM_MASTER_SCRUB_EN zeroes the whole memory after every reset.
module dram_block_master #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-4:0]   req_slot,
   input  logic [8*DATA_W-1:0] req_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [8*DATA_W-1:0] rsp_data,
   output logic                mem_en,
   output logic                mem_wr0,
   output logic                mem_wr1,
   output logic [ADDR_W-1:0]   mem_add0,
   output logic [ADDR_W-1:0]   mem_add1,
   output logic [DATA_W-1:0]   mem_data0_in,
   output logic [DATA_W-1:0]   mem_data1_in,
   input  logic [DATA_W-1:0]   mem_data0_out,
   input  logic [DATA_W-1:0]   mem_data1_out
);

   localparam int unsigned BlkW  = 8 * DATA_W;
   localparam int unsigned PairW = 2 * DATA_W;

`ifdef DRAM_MASTER_SCRUB_EN
   typedef enum logic [2:0] {StIdle, StWrite, StRead, StCapture, StResp, StScrub} state_e;
   localparam state_e ResetState = StScrub;
   localparam logic   ReadyRst   = 1'b0;
   localparam logic [ADDR_W-1:0] ScrubN = ADDR_W'(2 ** (ADDR_W - 1));
   logic [ADDR_W-1:0] scrub_q, scrub_d;
`else
   typedef enum logic [2:0] {StIdle, StWrite, StRead, StCapture, StResp} state_e;
   localparam state_e ResetState = StIdle;
   localparam logic   ReadyRst   = 1'b1;
`endif

   state_e              state_q, state_d;
   logic [1:0]          beat_q, beat_d, beat_nxt;
   logic [ADDR_W-4:0]   slot_q, slot_d;
   logic [BlkW-1:0]     buf_q, buf_d;
   logic                req_ready_d, rsp_valid_d, mem_en_d, mem_wr_d;
   logic [BlkW-1:0]     rsp_data_d;
   logic [ADDR_W-1:0]   add0_d, add1_d;
   logic [PairW-1:0]    wdata_d;

   // buf_q is a shift register: writes shift pending byte pairs out of the top,
   // reads shift captured pairs in at the bottom.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      beat_nxt    = beat_q + 2'd1;
      slot_d      = slot_q;
      buf_d       = buf_q;
      req_ready_d = req_ready;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b1;
      add0_d      = mem_add0;
      add1_d      = mem_add1;
      wdata_d     = {mem_data0_in, mem_data1_in};
`ifdef DRAM_MASTER_SCRUB_EN
      scrub_d     = scrub_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d     = req_write ? StWrite : StRead;
               beat_d      = 2'd0;
               slot_d      = req_slot;
               buf_d       = {req_data[BlkW-PairW-1:0], {PairW{1'b0}}};
               req_ready_d = 1'b0;
               mem_en_d    = 1'b1;
               mem_wr_d    = ~req_write;
               add0_d      = {req_slot, 2'd0, 1'b0};
               add1_d      = {req_slot, 2'd0, 1'b1};
               wdata_d     = req_data[BlkW-1 -: PairW];
            end
         end
         StWrite: begin
            if (beat_q == 2'd3) begin
               state_d     = StIdle;
               req_ready_d = 1'b1;
            end else begin
               beat_d   = beat_nxt;
               mem_en_d = 1'b1;
               mem_wr_d = 1'b0;
               add0_d   = {slot_q, beat_nxt, 1'b0};
               add1_d   = {slot_q, beat_nxt, 1'b1};
               wdata_d  = buf_q[BlkW-1 -: PairW];
               buf_d    = buf_q << PairW;
            end
         end
         StRead: begin
            mem_en_d = 1'b1;
            // Memory data lags the address by one cycle, so beat k-1 lands here.
            if (beat_q != 2'd0) begin
               buf_d = {buf_q[BlkW-PairW-1:0], mem_data0_out, mem_data1_out};
            end
            if (beat_q == 2'd3) begin
               state_d = StCapture;
            end else begin
               beat_d = beat_nxt;
               add0_d = {slot_q, beat_nxt, 1'b0};
               add1_d = {slot_q, beat_nxt, 1'b1};
            end
         end
         StCapture: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {buf_q[BlkW-PairW-1:0], mem_data0_out, mem_data1_out};
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
`ifdef DRAM_MASTER_SCRUB_EN
         StScrub: begin
            if (scrub_q == ScrubN) begin
               state_d     = StIdle;
               req_ready_d = 1'b1;
            end else begin
               mem_en_d = 1'b1;
               mem_wr_d = 1'b0;
               add0_d   = {scrub_q[ADDR_W-2:0], 1'b0};
               add1_d   = {scrub_q[ADDR_W-2:0], 1'b1};
               wdata_d  = '0;
               scrub_d  = scrub_q + ADDR_W'(1);
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ResetState;
         beat_q       <= 2'd0;
         slot_q       <= '0;
         buf_q        <= '0;
         req_ready    <= ReadyRst;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         mem_en       <= 1'b0;
         mem_wr0      <= 1'b1;
         mem_wr1      <= 1'b1;
         mem_add0     <= '0;
         mem_add1     <= '0;
         mem_data0_in <= '0;
         mem_data1_in <= '0;
`ifdef DRAM_MASTER_SCRUB_EN
         scrub_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         slot_q       <= slot_d;
         buf_q        <= buf_d;
         req_ready    <= req_ready_d;
         rsp_valid    <= rsp_valid_d;
         rsp_data     <= rsp_data_d;
         mem_en       <= mem_en_d;
         mem_wr0      <= mem_wr_d;
         mem_wr1      <= mem_wr_d;
         mem_add0     <= add0_d;
         mem_add1     <= add1_d;
         mem_data0_in <= wdata_d[PairW-1:DATA_W];
         mem_data1_in <= wdata_d[DATA_W-1:0];
`ifdef DRAM_MASTER_SCRUB_EN
         scrub_q      <= scrub_d;
`endif
      end
   end

endmodule

// File: tb/tb_dram_block_master.sv
// Directed bench for dram_block_master with a behavioural dual-port memory attached.
// Define DRAM_MASTER_SCRUB_EN for bench and RTL together to cover the scrub-after-reset path.
module tb_dram_block_master;

`ifdef DRAM_MASTER_SCRUB_EN
   localparam logic        ReadyRst = 1'b0;
   localparam logic [7:0]  PreVal   = 8'hAA;
   localparam logic [63:0] ExpSlot1 = 64'h0;
`else
   localparam logic        ReadyRst = 1'b1;
   localparam logic [7:0]  PreVal   = 8'h00;
   localparam logic [63:0] ExpSlot1 = 64'h2222_0000_0000_0000;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_slot;
   logic [63:0] req_data;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic        mem_en, mem_wr0, mem_wr1;
   logic [5:0]  mem_add0, mem_add1;
   logic [7:0]  mem_data0_in, mem_data1_in, mem_data0_out, mem_data1_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dram_block_master dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_slot      (req_slot),
      .req_data      (req_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .mem_en        (mem_en),
      .mem_wr0       (mem_wr0),
      .mem_wr1       (mem_wr1),
      .mem_add0      (mem_add0),
      .mem_add1      (mem_add1),
      .mem_data0_in  (mem_data0_in),
      .mem_data1_in  (mem_data1_in),
      .mem_data0_out (mem_data0_out),
      .mem_data1_out (mem_data1_out)
   );

   // Memory: registered read ports, outputs cleared when disabled; wmask records written addresses.
   logic [7:0]  mem [64];
   logic [63:0] wmask;
   logic        preload, mon_clr;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= PreVal;
      end else if (mem_en) begin
         if (!mem_wr0) mem[mem_add0] <= mem_data0_in;
         if (!mem_wr1) mem[mem_add1] <= mem_data1_in;
      end
      if (mon_clr) begin
         wmask <= '0;
      end else if (mem_en) begin
         if (!mem_wr0) wmask[mem_add0] <= 1'b1;
         if (!mem_wr1) wmask[mem_add1] <= 1'b1;
      end
      if (mem_en) begin
         mem_data0_out <= mem[mem_add0];
         mem_data1_out <= mem[mem_add1];
      end else begin
         mem_data0_out <= '0;
         mem_data1_out <= '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   // Presents one request for exactly one edge; returns in the first cycle after acceptance.
   task automatic issue(input logic wr, input logic [2:0] slot, input logic [63:0] data);
      req_valid = 1'b1;
      req_write = wr;
      req_slot  = slot;
      req_data  = data;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_reset();
      int n_ok;
      int cyc;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_ctl", 64'({req_ready, rsp_valid, mem_en, mem_wr0, mem_wr1}),
            64'({ReadyRst, 4'b0011}));
      check("rst_addr_data", 64'({mem_add0, mem_add1, mem_data0_in, mem_data1_in}), 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      rst_n = 1'b1;
`ifdef DRAM_MASTER_SCRUB_EN
      n_ok = 0;
      cyc  = 0;
      do begin
         tick();
         cyc++;
         if (mem_en && !mem_wr0 && !mem_wr1 && !req_ready && mem_add0 == 6'(2 * n_ok) &&
             mem_add1 == 6'(2 * n_ok + 1) && mem_data0_in == 8'h0 && mem_data1_in == 8'h0)
            n_ok++;
      end while (!req_ready && cyc < 100);
      check("scrub_writes", 64'(n_ok), 64'd32);
      check("scrub_ready_cycle", 64'(cyc), 64'd33);
`else
      n_ok = 0;
      cyc  = 0;
      tick();
      check("ready_after_release", 64'(req_ready), 64'd1);
`endif
   endtask

   task automatic write_block(input logic [2:0] slot, input logic [63:0] data);
      logic [31:0] exp;
      check("wr_ready_in", 64'(req_ready), 64'd1);
      issue(1'b1, slot, data);
      for (int k = 0; k < 4; k++) begin
         exp = {4'b0100, slot, 2'(k), 1'b0, slot, 2'(k), 1'b1, data[63-16*k -: 16]};
         check($sformatf("wr_s%0d_beat%0d", slot, k),
               64'({req_ready, mem_en, mem_wr0, mem_wr1, mem_add0, mem_add1,
                    mem_data0_in, mem_data1_in}), 64'(exp));
         tick();
      end
      check("wr_done", 64'({req_ready, mem_en, mem_wr0, mem_wr1}), 64'b1011);
   endtask

   task automatic read_block(input logic [2:0] slot, input int hold, input logic spam,
                             input logic [63:0] exp);
      int          lat;
      logic [63:0] first;
      logic        stable;
      pulse_clr();
      check("rd_ready_in", 64'(req_ready), 64'd1);
      rsp_ready = 1'b0;
      issue(1'b0, slot, 64'h0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check($sformatf("rd_s%0d_latency", slot), 64'(lat), 64'd6);
      check($sformatf("rd_s%0d_data", slot), rsp_data, exp);
      first  = rsp_data;
      stable = 1'b1;
      if (spam) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_slot  = 3'd3;
         req_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!rsp_valid || rsp_data !== first || req_ready || mem_en) stable = 1'b0;
      end
      req_valid = 1'b0;
      if (hold > 0) check("rd_hold_stable", 64'(stable), 64'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rd_done", 64'({rsp_valid, req_ready}), 64'b01);
      tick();
      check("rd_idle_after", 64'({req_ready, mem_en}), 64'b10);
      check("rd_no_writes", wmask, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no $finish, expected one within 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_slot  = 3'd0;
      req_data  = 64'h0;
      rsp_ready = 1'b0;
      preload   = 1'b1;
      mon_clr   = 1'b1;
      tick();
      preload = 1'b0;
      mon_clr = 1'b0;

      do_reset();
`ifdef DRAM_MASTER_SCRUB_EN
      for (int s = 0; s < 8; s++) read_block(3'(s), 0, 1'b0, 64'h0);
`endif

      write_block(3'd0, 64'h1111_1111_1111_1111);
      write_block(3'd2, 64'h0123_4567_89AB_CDEF);
      read_block(3'd2, 0, 1'b0, 64'h0123_4567_89AB_CDEF);
      read_block(3'd2, 10, 1'b1, 64'h0123_4567_89AB_CDEF);

      pulse_clr();
      write_block(3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      check("slot7_addr_only", wmask, 64'hFF00_0000_0000_0000);
      read_block(3'd0, 0, 1'b0, 64'h1111_1111_1111_1111);
      read_block(3'd7, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

      // Reset lands on the edge ending beat 0 of a slot-1 write.
      pulse_clr();
      issue(1'b1, 3'd1, 64'h2222_2222_2222_2222);
      rst_n = 1'b0;
      tick();
      check("rst_mid_ctl", 64'({req_ready, mem_en, mem_wr0, mem_wr1}), 64'({ReadyRst, 3'b011}));
      rst_n = 1'b1;
`ifdef DRAM_MASTER_SCRUB_EN
      for (int i = 0; i < 100 && !req_ready; i++) tick();
      check("scrub_rerun_ready", 64'(req_ready), 64'd1);
`else
      tick();
      tick();
      check("rst_mid_mask", wmask, 64'h0000_0000_0000_0300);
`endif
      read_block(3'd1, 0, 1'b0, ExpSlot1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
